vdg_fetch_timer: RTL and testbench

//  Video timing and display-RAM byte fetch stage feeding the pixel shifter (shifter inputs inData/load/divider/mode).

---
 rtl/vdg_fetch_timer.sv | 132 +++++++++++++
 tb/tb_vdg_fetch_timer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/vdg_fetch_timer.sv
// Video timing and display-RAM fetch for the pixel shifter: counters, sync/blank, RAM address, byte load strobe.
// Optional VDG_ROW_REPEAT_EN: latched mode[3] shows each display row on two consecutive lines.
module vdg_fetch_timer #(
    parameter int unsigned H_ACTIVE    = 256,
    parameter int unsigned H_TOTAL     = 320,
    parameter int unsigned HSYNC_START = 272,
    parameter int unsigned HSYNC_LEN   = 24,
    parameter int unsigned V_ACTIVE    = 192,
    parameter int unsigned V_TOTAL     = 262,
    parameter int unsigned VSYNC_START = 220,
    parameter int unsigned VSYNC_LEN   = 3,
    parameter int unsigned ADDR_W      = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [7:0]        ram_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        shift_data,
    output logic              load,
    output logic              divider,
    output logic              hsync,
    output logic              vsync,
    output logic              blank
);

    localparam int unsigned HW = $clog2(H_TOTAL);
    localparam int unsigned VW = $clog2(V_TOTAL);

    logic [HW-1:0]     hcount;
    logic [HW-1:0]     hn;
    logic [VW-1:0]     vcount;
    logic [VW-1:0]     vn;
    logic              line_end;
    logic [HW-1:0]     slot_mask;
    logic              h_act;
    logic              v_act;
    logic              last_h;
    logic              frame_issue;
    logic              line_issue;
    logic              mid_issue;
    logic              load_slot;
    logic              border_slot;
    logic [ADDR_W-1:0] line_addr;
    logic              unused_mode;

`ifdef VDG_ROW_REPEAT_EN
    logic row_rep;
    assign unused_mode = ^mode[2:1];
`else
    assign unused_mode = ^mode[3:1];
`endif

    // Next raster position; every registered output describes this position.
    always_comb begin
        line_end = (hcount == HW'(H_TOTAL - 1));
        hn       = line_end ? '0 : hcount + HW'(1);
        vn       = vcount;
        if (line_end) begin
            vn = (vcount == VW'(V_TOTAL - 1)) ? '0 : vcount + VW'(1);
        end
    end

    // Fetch slots: addresses issue one clock before the matching load slot.
    always_comb begin
        slot_mask   = divider ? HW'(3) : HW'(7);
        h_act       = (32'(hn) < H_ACTIVE);
        v_act       = (32'(vn) < V_ACTIVE);
        last_h      = (hn == HW'(H_TOTAL - 1));
        frame_issue = last_h && (vn == VW'(V_TOTAL - 1));
        line_issue  = last_h && ((32'(vn) + 32'd1) < V_ACTIVE);
        mid_issue   = v_act && ((hn & slot_mask) == slot_mask) && ((32'(hn) + 32'd1) < H_ACTIVE);
        load_slot   = v_act && h_act && ((hn & slot_mask) == '0);
        border_slot = v_act && (32'(hn) == H_ACTIVE);
        line_addr   = ram_addr + ADDR_W'(1);
`ifdef VDG_ROW_REPEAT_EN
        // Even line ends: step back one line so the odd line refetches the same row.
        if (row_rep && !vn[0]) begin
            line_addr = line_addr - (divider ? ADDR_W'(H_ACTIVE / 4) : ADDR_W'(H_ACTIVE / 8));
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hcount     <= '0;
            vcount     <= '0;
            divider    <= 1'b0;
            ram_addr   <= base_addr;
            shift_data <= '0;
            load       <= 1'b0;
            hsync      <= 1'b0;
            vsync      <= 1'b0;
            blank      <= 1'b1;
        end else begin
            hcount <= hn;
            vcount <= vn;
            if ((hn == '0) && (vn == '0)) begin
                divider <= mode[0];
            end
            // Frame reload takes priority over the line-start issue on the same clock.
            if (frame_issue) begin
                ram_addr <= base_addr;
            end else if (line_issue) begin
                ram_addr <= line_addr;
            end else if (mid_issue) begin
                ram_addr <= ram_addr + ADDR_W'(1);
            end
            load <= load_slot || border_slot;
            if (load_slot) begin
                shift_data <= ram_data;
            end else if (!h_act || !v_act) begin
                shift_data <= '0;
            end
            hsync <= (32'(hn) >= HSYNC_START) && (32'(hn) < (HSYNC_START + HSYNC_LEN));
            vsync <= (32'(vn) >= VSYNC_START) && (32'(vn) < (VSYNC_START + VSYNC_LEN));
            blank <= !h_act || !v_act;
        end
    end

`ifdef VDG_ROW_REPEAT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            row_rep <= 1'b0;
        end else if ((hn == '0) && (vn == '0)) begin
            row_rep <= mode[3];
        end
    end
`endif

endmodule

// File: tb/tb_vdg_fetch_timer.sv
// Bench for vdg_fetch_timer on a reduced raster; a position-based reference model predicts every output each clock.
module tb_vdg_fetch_timer;

    localparam int HA = 64;
    localparam int HT = 80;
    localparam int HS = 68;
    localparam int HL = 6;
    localparam int VA = 8;
    localparam int VT = 12;
    localparam int VS = 9;
    localparam int VL = 2;
    localparam int AW = 13;
`ifdef VDG_ROW_REPEAT_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [3:0]    mode = 4'd0;
    logic [AW-1:0] base_addr = 13'h0400;
    logic [7:0]    ram_data;
    logic [AW-1:0] ram_addr;
    logic [7:0]    shift_data;
    logic          load;
    logic          divider;
    logic          hsync;
    logic          vsync;
    logic          blank;

    logic [7:0] mem [0:(1<<AW)-1];
    assign ram_data = mem[ram_addr];

    always #5 clk = ~clk;

    vdg_fetch_timer #(
        .H_ACTIVE(HA), .H_TOTAL(HT), .HSYNC_START(HS), .HSYNC_LEN(HL),
        .V_ACTIVE(VA), .V_TOTAL(VT), .VSYNC_START(VS), .VSYNC_LEN(VL), .ADDR_W(AW)
    ) dut (
        .clk(clk), .reset(reset), .mode(mode), .base_addr(base_addr), .ram_data(ram_data),
        .ram_addr(ram_addr), .shift_data(shift_data), .load(load), .divider(divider),
        .hsync(hsync), .vsync(vsync), .blank(blank)
    );

    // Reference state: raster position plus the parameters in force for the current frame.
    int            h = 0;
    int            v = 0;
    bit            in_rst = 1'b1;
    bit            post = 1'b1;
    bit            fdiv = 1'b0;
    bit            frr = 1'b0;
    logic [AW-1:0] fbase = '0;
    logic [AW-1:0] nbase = '0;
    int            checks = 0;
    int            errors = 0;
    int            n_load = 0;
    int            n_hs = 0;
    int            n_vs = 0;

    function automatic logic [AW-1:0] addr_of(input int vv, input int k);
        int bb  = fdiv ? HA / 4 : HA / 8;
        int row = (RR_EN && frr) ? vv / 2 : vv;
        return AW'(int'(fbase) + row * bb + k);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s h=%0d v=%0d observed=%0h expected=%0h", tag, h, v, obs, exp);
        end
    endtask

    task automatic step();
        int            ii;
        int            bb;
        logic [AW-1:0] e_addr;
        logic [7:0]    e_shift;
        @(posedge clk);
        if (reset) begin
            h = 0; v = 0; in_rst = 1'b1; post = 1'b1;
            fdiv = 1'b0; frr = 1'b0; fbase = base_addr;
        end else begin
            in_rst = 1'b0;
            h++;
            if (h == HT) begin
                h = 0;
                v = (v == VT - 1) ? 0 : v + 1;
            end
            if (h == HT - 1 && v == VT - 1) nbase = base_addr;
            if (h == 0 && v == 0) begin
                fdiv = mode[0]; frr = mode[3]; fbase = nbase; post = 1'b0;
            end
        end
        #1;
        ii = fdiv ? 4 : 8;
        bb = HA / ii;
        if (in_rst)                        e_addr = fbase;
        else if (h == HT - 1 && v == VT - 1) e_addr = nbase;
        else if (h == HT - 1 && v + 1 < VA) e_addr = addr_of(v + 1, 0);
        else if (v < VA)                   e_addr = (h < HA - 1) ? addr_of(v, (h + 1) / ii) : addr_of(v, bb - 1);
        else                               e_addr = addr_of(VA - 1, bb - 1);
        if (!in_rst && v < VA && h < HA && !(post && v == 0 && h < ii))
            e_shift = mem[addr_of(v, h / ii)];
        else
            e_shift = 8'h00;
        chk("ram_addr", 32'(ram_addr), 32'(e_addr));
        chk("shift_data", 32'(shift_data), 32'(e_shift));
        chk("load", 32'(load), 32'(!in_rst && v < VA && h <= HA && (h % ii) == 0));
        chk("divider", 32'(divider), 32'(fdiv));
        chk("hsync", 32'(hsync), 32'(!in_rst && h >= HS && h < HS + HL));
        chk("vsync", 32'(vsync), 32'(!in_rst && v >= VS && v < VS + VL));
        chk("blank", 32'(blank), 32'(in_rst || h >= HA || v >= VA));
        n_load += int'(load);
        n_hs   += int'(hsync);
        n_vs   += int'(vsync);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic frame_totals(input int exp_loads);
        chk("loads_per_frame", 32'(n_load), 32'(exp_loads));
        chk("hsync_clks_per_frame", 32'(n_hs), 32'(HL * VT));
        chk("vsync_clks_per_frame", 32'(n_vs), 32'(VL * HT));
        n_load = 0; n_hs = 0; n_vs = 0;
    endtask

    initial begin
        int exp_loads;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'(i);

        // Power-up reset, then a partial-first frame with mode 0 / base 0x0400.
        run(3);
        reset = 1'b0;
        n_load = 0; n_hs = 0; n_vs = 0;
        run(HT * VT);
        frame_totals(VA * (HA / 8 + 1));

        // Full frame mode 0; a mode write at line 5 must wait for the next frame.
        run(HT * 5);
        mode = 4'b0001;
        run(HT * (VT - 5));
        frame_totals(VA * (HA / 8 + 1));

        // 2bpp frame; queue a base near the top of the address space.
        run(HT * 5);
        mode = 4'b0000;
        base_addr = 13'h1FF0;
        run(HT * (VT - 5));
        frame_totals(VA * (HA / 4 + 1));

        // Address wrap 0x1FFF -> 0x0000; then request row repeat.
        run(HT * 5);
        mode = 4'b1000;
        base_addr = 13'h0400;
        run(HT * (VT - 5));
        frame_totals(VA * (HA / 8 + 1));

        // Row-repeat request frame; refill memory with random bytes during vertical blank.
        run(HT * (VA + 1));
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'($urandom);
        mode = 4'($urandom);
        base_addr = AW'($urandom);
        run(HT * (VT - VA - 1));
        frame_totals(VA * (HA / 8 + 1));

        // Random frames.
        for (int f = 0; f < 3; f++) begin
            exp_loads = VA * ((fdiv ? HA / 4 : HA / 8) + 1);
            run(HT * (VA + 1));
            for (int i = 0; i < (1 << AW); i++) mem[i] = 8'($urandom);
            mode = 4'($urandom);
            base_addr = AW'($urandom);
            run(HT * (VT - VA - 1));
            frame_totals(exp_loads);
        end

        // Reset held three clocks in the middle of an active line.
        run(HT * 2 + 37);
        reset = 1'b1;
        mode = 4'b0001;
        base_addr = 13'h0123;
        run(3);
        reset = 1'b0;
        n_load = 0; n_hs = 0; n_vs = 0;
        run(HT * VT);
        frame_totals(VA * (HA / 8 + 1));
        run(HT * 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
